// File: rtl/seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
//   Registered hex-to-seven-segment decoder for the pong score display.
//   A 4-bit hex digit is decoded into the seven segment drive lines a..g and
//   captured in a register, so the pins change only on a clock edge and never
//   glitch while the digit-mux logic upstream settles.
//
// Parameters
//   ACTIVE_LOW  1: segment lit when its line is 0 (common-anode board)
//               0: segment lit when its line is 1
//
// Ports
//   clk        system clock, rising-edge active
//   rst        synchronous reset, active-low; blanks the display
//   Din[3:0]   hex digit to display (0..F)
//   a..g       segment lines (a top, b upper right, c lower right, d bottom,
//              e lower left, f upper left, g middle)
//
// Latency: Din sampled on edge N is visible on a..g right after edge N.
// -----------------------------------------------------------------------------
module seven_seg_decoder #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Din,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  // Segment vectors are ordered {a,b,c,d,e,f,g}, MSB = a.
  localparam logic [6:0] SEG_BLANK = ACTIVE_LOW ? 7'b111_1111 : 7'b000_0000;

  // Glyph table in lit-high form. An unknown digit falls to all-off so a
  // floating input shows up as a dark digit rather than a bogus glyph.
  function automatic logic [6:0] lit_pattern(input logic [3:0] digit);
    logic [6:0] lit;
    case (digit)
      4'h0:    lit = 7'b111_1110;
      4'h1:    lit = 7'b011_0000;
      4'h2:    lit = 7'b110_1101;
      4'h3:    lit = 7'b111_1001;
      4'h4:    lit = 7'b011_0011;
      4'h5:    lit = 7'b101_1011;
      4'h6:    lit = 7'b101_1111;
      4'h7:    lit = 7'b111_0000;
      4'h8:    lit = 7'b111_1111;
      4'h9:    lit = 7'b111_1011;
      4'hA:    lit = 7'b111_0111;
      4'hB:    lit = 7'b001_1111;
      4'hC:    lit = 7'b100_1110;
      4'hD:    lit = 7'b011_1101;
      4'hE:    lit = 7'b100_1111;
      4'hF:    lit = 7'b100_0111;
      default: lit = 7'b000_0000;
    endcase
    return lit;
  endfunction

  // Map lit-high form onto the board's pin polarity.
  function automatic logic [6:0] pin_polarity(input logic [6:0] lit);
    return ACTIVE_LOW ? ~lit : lit;
  endfunction

  logic [6:0] seg_d;
  logic [6:0] seg_q;

  // ---- decode (combinational, feeds the output register) ----
  always_comb begin
    seg_d = pin_polarity(lit_pattern(Din));
  end

  // ---- output register: pins driven only from here ----
  // Reset blanks the display; the first edge after release loads a glyph
  // directly, with no extra blank cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_q <= SEG_BLANK;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign a = seg_q[6];
  assign b = seg_q[5];
  assign c = seg_q[4];
  assign d = seg_q[3];
  assign e = seg_q[2];
  assign f = seg_q[1];
  assign g = seg_q[0];

endmodule

// File: tb/tb_seven_seg_decoder.sv
module tb_seven_seg_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] Din;

  logic a1, b1, c1, d1, e1, f1, g1;   // ACTIVE_LOW = 1 build
  logic a0, b0, c0, d0, e0, f0, g0;   // ACTIVE_LOW = 0 build

  int pass_cnt  = 0;
  int total_cnt = 0;

  seven_seg_decoder #(.ACTIVE_LOW(1'b1)) dut_al1 (
    .clk(clk), .rst(rst), .Din(Din),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1)
  );

  seven_seg_decoder #(.ACTIVE_LOW(1'b0)) dut_al0 (
    .clk(clk), .rst(rst), .Din(Din),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lit-high glyphs {a..g} as listed for the score display.
  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  wire [6:0] seg1 = {a1, b1, c1, d1, e1, f1, g1};
  wire [6:0] seg0 = {a0, b0, c0, d0, e0, f0, g0};

  // Reference: what each build must show after the most recent edge.
  logic [6:0] exp1, exp0;
  logic       chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      exp1 <= 7'b1111111;
      exp0 <= 7'b0000000;
    end else begin
      exp1 <= ~glyph[Din];
      exp0 <=  glyph[Din];
    end
    chk_en <= 1'b1;
  end

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous comparison, sampled on the inactive edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_al1", seg1, exp1);
      check("model_al0", seg0, exp0);
    end
  end

  // Drive inputs just after the falling edge, clear of both the active edge
  // and the compare process.
  task automatic drive(input logic r, input logic [3:0] v);
    @(negedge clk);
    #1;
    rst = r;
    Din = v;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    Din = 4'h8;

    // Reset holds blank even with an 8 (all segments) presented.
    after_edge();
    after_edge();
    check("reset_blank_al1", seg1, 7'b1111111);
    check("reset_blank_al0", seg0, 7'b0000000);

    // Release with Din=0: still blank until the next edge, then the 0 glyph.
    drive(1'b1, 4'h0);
    check("release_pre_edge", seg1, 7'b1111111);
    after_edge();
    check("release_digit0", seg1, 7'b0000001);

    // Sweep every code, one per cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i));
      after_edge();
      case (i)
        1:  check("sweep_1", seg1, 7'b1001111);
        9:  check("sweep_9", seg1, 7'b0000100);
        11: check("sweep_b", seg1, 7'b1100000);
        15: check("sweep_F", seg1, 7'b0111000);
        default: ;
      endcase
    end

    // Latency: a mid-cycle change of Din has no effect until the next edge.
    drive(1'b1, 4'h3);
    after_edge();
    check("latency_3", seg1, 7'b0000110);
    #2 Din = 4'h7;
    #1 check("latency_hold", seg1, 7'b0000110);
    after_edge();
    check("latency_7", seg1, 7'b0001111);

    // Reset in mid-display blanks regardless of Din, release resumes at once.
    drive(1'b1, 4'h5);
    after_edge();
    check("show_5", seg1, 7'b0100100);
    drive(1'b0, 4'h5);
    after_edge();
    check("midreset_blank", seg1, 7'b1111111);
    drive(1'b1, 4'h5);
    after_edge();
    check("midreset_release_5", seg1, 7'b0100100);

    // Active-high build.
    drive(1'b1, 4'h2);
    after_edge();
    check("al0_digit2", seg0, 7'b1101101);
    drive(1'b0, 4'h2);
    after_edge();
    check("al0_reset", seg0, 7'b0000000);

    // Randomized digits with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #2 Din = 4'($urandom_range(0, 15));
      end
    end

    drive(1'b1, 4'h0);
    after_edge();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
